dw_lsd_denorm: RTL and testbench

- Iterative sign-restoring denormalizer. It is the inverse partner of the leading-sign-detect encoder.
- Takes a normalized two's-complement operand plus its leading-sign count `enc`, and arithmetic-right-shifts the operand by `enc`. This re-inserts the sign bits that normalization removed.
- Sits after the NPU normalize/multiply path, ahead of writeback. Valid/ready on both sides; the shift runs over multiple cycles, `step` bits per cycle.

---
 rtl/dw_lsd_denorm_if.sv | 45 ++++
 rtl/dw_lsd_denorm.sv | 140 ++++++++++++++
 tb/tb_dw_lsd_denorm.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dw_lsd_denorm_if.sv
// ============================================================================
// Module      : dw_lsd_denorm_if
// Description : Operand/result handshake bundle for the dw_lsd_denorm
//               iterative sign-restoring denormalizer.
//               Optional macro DW_LSD_DENORM_STICKY_EN adds the sticky output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dw_lsd_denorm_if #(
  parameter int A_WIDTH    = 8,
  parameter int ADDR_WIDTH = (A_WIDTH > 1) ? $clog2(A_WIDTH) : 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [A_WIDTH-1:0]    a;
  logic [ADDR_WIDTH-1:0] enc;
  logic                  out_valid;
  logic                  out_ready;
  logic [A_WIDTH-1:0]    res;
  logic                  busy;
`ifdef DW_LSD_DENORM_STICKY_EN
  logic                  sticky;
`endif

  // Producer/consumer side: offers operands, accepts results
  modport master (
    output in_valid, a, enc, out_ready,
`ifdef DW_LSD_DENORM_STICKY_EN
    input  sticky,
`endif
    input  in_ready, out_valid, res, busy
  );

  // Denormalizer side
  modport slave (
    input  in_valid, a, enc, out_ready,
`ifdef DW_LSD_DENORM_STICKY_EN
    output sticky,
`endif
    output in_ready, out_valid, res, busy
  );
endinterface

`default_nettype wire

// File: rtl/dw_lsd_denorm.sv
// ============================================================================
// Module      : dw_lsd_denorm
// Description : Iterative sign-restoring denormalizer. Arithmetic-right-shifts
//               a normalized two's-complement operand by its leading-sign
//               count, at most STEP bits per cycle, with valid/ready on both
//               sides. Shift counts >= A_WIDTH saturate to A_WIDTH-1.
//               Optional macro DW_LSD_DENORM_STICKY_EN adds a sticky output
//               (OR of all bits shifted out of the LSB).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dw_lsd_denorm #(
  parameter int A_WIDTH = 8,
  parameter int STEP    = 1
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  dw_lsd_denorm_if.slave bus
);

  localparam int ADDR_WIDTH = (A_WIDTH > 1) ? $clog2(A_WIDTH) : 1;
  // A step wider than the largest legal shift behaves like the largest shift
  localparam int STEP_EFF   = (STEP < A_WIDTH - 1) ? STEP : A_WIDTH - 1;

  localparam logic [ADDR_WIDTH-1:0] c_max_shift = ADDR_WIDTH'(A_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] c_step      = ADDR_WIDTH'(STEP_EFF);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [A_WIDTH-1:0]    shreg_q, shreg_d;
  logic [ADDR_WIDTH-1:0] rem_q,   rem_d;
  logic [A_WIDTH-1:0]    res_q,   res_d;
`ifdef DW_LSD_DENORM_STICKY_EN
  logic                  sticky_q, sticky_d;
  logic                  w_lost;
`endif

  logic [ADDR_WIDTH-1:0] w_enc_sat;
  logic [ADDR_WIDTH-1:0] w_k;
  logic [A_WIDTH-1:0]    w_shifted;

  // Counts past the top bit (non-power-of-two widths) shift out everything
  // but the sign, which is exactly what A_WIDTH-1 already does.
  assign w_enc_sat = (32'(bus.enc) > 32'(A_WIDTH - 1)) ? c_max_shift : bus.enc;

  // Bits to shift this cycle: min(remaining, step)
  assign w_k       = (rem_q > c_step) ? c_step : rem_q;
  assign w_shifted = A_WIDTH'($signed(shreg_q) >>> w_k);

`ifdef DW_LSD_DENORM_STICKY_EN
  // Any set bit below the shift point is about to fall off the LSB
  assign w_lost = |(shreg_q & ~({A_WIDTH{1'b1}} << w_k));
`endif

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    rem_d    = rem_q;
    res_d    = res_q;
`ifdef DW_LSD_DENORM_STICKY_EN
    sticky_d = sticky_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          shreg_d  = bus.a;
          rem_d    = w_enc_sat;
`ifdef DW_LSD_DENORM_STICKY_EN
          sticky_d = 1'b0;
`endif
          if (w_enc_sat == '0) begin
            state_d = S_DONE;
            res_d   = bus.a;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        shreg_d  = w_shifted;
        rem_d    = rem_q - w_k;
`ifdef DW_LSD_DENORM_STICKY_EN
        sticky_d = sticky_q | w_lost;
`endif
        // Result is published only on the transition into DONE
        if (rem_q == w_k) begin
          state_d = S_DONE;
          res_d   = w_shifted;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      rem_q    <= '0;
      res_q    <= '0;
`ifdef DW_LSD_DENORM_STICKY_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      rem_q    <= rem_d;
      res_q    <= res_d;
`ifdef DW_LSD_DENORM_STICKY_EN
      sticky_q <= sticky_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.res       = res_q;
`ifdef DW_LSD_DENORM_STICKY_EN
  assign bus.sticky    = sticky_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dw_lsd_denorm.sv
// ============================================================================
// Module      : tb_dw_lsd_denorm
// Description : Scoreboard bench for dw_lsd_denorm. Two instances
//               (8-bit/step 1 and 12-bit/step 4) share one driver/monitor
//               pair indexed by instance. Expected results come from a
//               signed floor-division model. Honors DW_LSD_DENORM_STICKY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dw_lsd_denorm;

  localparam int W0 = 8;
  localparam int S0 = 1;
  localparam int W1 = 12;
  localparam int S1 = 4;

  typedef struct {
    logic [11:0] res;
    logic        stk;
    int          lat;
    int          hold;
    int          c0;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  logic [1:0]       drv_valid = '0;
  logic [1:0][11:0] drv_a     = '0;
  logic [1:0][3:0]  drv_enc   = '0;
  logic [1:0]       drv_ready = '0;

  logic [1:0]       mon_valid;
  logic [1:0]       mon_in_ready;
  logic [1:0]       mon_busy;
  logic [1:0][11:0] mon_res;
  logic [1:0]       mon_stk;

  exp_t q0[$];
  exp_t q1[$];

  dw_lsd_denorm_if #(.A_WIDTH(W0)) if0 ();
  dw_lsd_denorm_if #(.A_WIDTH(W1)) if1 ();

  dw_lsd_denorm #(.A_WIDTH(W0), .STEP(S0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  dw_lsd_denorm #(.A_WIDTH(W1), .STEP(S1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if0.in_valid  = drv_valid[0];
  assign if0.a         = drv_a[0][7:0];
  assign if0.enc       = drv_enc[0][2:0];
  assign if0.out_ready = drv_ready[0];
  assign if1.in_valid  = drv_valid[1];
  assign if1.a         = drv_a[1];
  assign if1.enc       = drv_enc[1];
  assign if1.out_ready = drv_ready[1];

  assign mon_valid[0]    = if0.out_valid;
  assign mon_valid[1]    = if1.out_valid;
  assign mon_in_ready[0] = if0.in_ready;
  assign mon_in_ready[1] = if1.in_ready;
  assign mon_busy[0]     = if0.busy;
  assign mon_busy[1]     = if1.busy;
  assign mon_res[0]      = {4'b0, if0.res};
  assign mon_res[1]      = if1.res;
`ifdef DW_LSD_DENORM_STICKY_EN
  assign mon_stk[0]      = if0.sticky;
  assign mon_stk[1]      = if1.sticky;
`else
  assign mon_stk         = '0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  function automatic int stp(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  // Reference: res = floor(signed(a) / 2^e), sticky = remainder nonzero
  function automatic exp_t model(input int i, input logic [11:0] a, input int enc,
                                 input int hold, input int c0);
    exp_t e;
    int   w, sh, v, p, r;
    w  = wid(i);
    sh = (enc > w - 1) ? w - 1 : enc;
    v  = int'(a) & ((1 << w) - 1);
    if (v >= (1 << (w - 1))) v = v - (1 << w);
    p  = 1 << sh;
    if (v >= 0) r = v / p;
    else        r = -((-v + p - 1) / p);
    e.res  = 12'(r & ((1 << w) - 1));
    e.stk  = (((int'(a) & ((1 << w) - 1)) % p) != 0);
    e.lat  = (sh + stp(i) - 1) / stp(i) + 1;
    e.hold = hold;
    e.c0   = c0;
    return e;
  endfunction

  task automatic chk(input int i, input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h expected %0h (cycle %0d)", i, nm, act, expv, cyc);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic pop(input int i, output exp_t e);
    if (i == 0) e = q0.pop_front();
    else        e = q1.pop_front();
  endtask

  // Offer one operand; returns #1 after the accept edge
  task automatic send(input int i, input logic [11:0] a, input int enc, input int hold,
                      input bit expect_result, output int c0);
    int t = 0;
    @(negedge clk);
    while (!mon_in_ready[i] && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      chk(i, "in_ready_wait", {31'b0, mon_in_ready[i]}, 1);
      c0 = -1;
      return;
    end
    c0 = cyc;
    drv_valid[i] = 1'b1;
    drv_a[i]     = a;
    drv_enc[i]   = 4'(enc);
    if (expect_result) push(i, model(i, a, enc, hold, c0));
    @(posedge clk);
    #1;
    drv_valid[i] = 1'b0;
    drv_a[i]     = 12'($urandom);
    drv_enc[i]   = 4'($urandom);
  endtask

  task automatic wait_drain(input int i);
    int t = 0;
    while ((qsize(i) != 0 || mon_busy[i]) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk(i, "drain_timeout", {31'b0, mon_busy[i]}, 0);
  endtask

  // Result side: pops on out_valid, applies the per-item back-pressure
  task automatic monitor(input int i);
    exp_t        cur;
    bit          seen = 1'b0;
    bit          pend = 1'b0;
    int          cnt  = 0;
    logic [11:0] held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
        pend = 1'b0;
        drv_ready[i] = 1'b0;
        continue;
      end
      if (pend) begin
        pend = 1'b0;
        drv_ready[i] = 1'b0;
        chk(i, "valid_after_ready", {31'b0, mon_valid[i]}, 0);
        chk(i, "in_ready_after_ready", {31'b0, mon_in_ready[i]}, 1);
        chk(i, "busy_after_ready", {31'b0, mon_busy[i]}, 0);
        continue;
      end
      if (mon_valid[i]) begin
        if (!seen) begin
          if (qsize(i) == 0) begin
            chk(i, "spurious_out_valid", {31'b0, mon_valid[i]}, 0);
            drv_ready[i] = 1'b1;
            pend = 1'b1;
            continue;
          end
          pop(i, cur);
          seen = 1'b1;
          cnt  = 0;
          held = mon_res[i];
          chk(i, "latency", 32'(cyc - cur.c0), 32'(cur.lat));
        end else begin
          chk(i, "res_hold", {20'b0, mon_res[i]}, {20'b0, held});
        end
        chk(i, "done_in_ready", {31'b0, mon_in_ready[i]}, 0);
        chk(i, "done_busy", {31'b0, mon_busy[i]}, 1);
        if (cnt >= cur.hold) begin
          chk(i, "result", {20'b0, mon_res[i]}, {20'b0, cur.res});
`ifdef DW_LSD_DENORM_STICKY_EN
          chk(i, "sticky", {31'b0, mon_stk[i]}, {31'b0, cur.stk});
`endif
          drv_ready[i] = 1'b1;
          pend = 1'b1;
          seen = 1'b0;
        end else begin
          cnt++;
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0a, c0b, dummy;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(i, "rst_in_ready", {31'b0, mon_in_ready[i]}, 1);
      chk(i, "rst_out_valid", {31'b0, mon_valid[i]}, 0);
      chk(i, "rst_busy", {31'b0, mon_busy[i]}, 0);
      chk(i, "rst_res", {20'b0, mon_res[i]}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    send(0, 12'h0B0, 3, 0, 1, dummy);
    wait_drain(0);
    send(0, 12'h05A, 0, 0, 1, c0a);
    send(0, 12'h0A5, 0, 0, 1, c0b);
    chk(0, "accept_spacing", 32'(c0b - c0a), 2);
    send(0, 12'h041, 7, 0, 1, dummy);
    send(0, 12'h080, 7, 1, 1, dummy);
    send(1, 12'h800, 14, 0, 1, dummy);
    send(1, 12'h7FF, 15, 0, 1, dummy);
    send(1, 12'h923, 5, 0, 1, dummy);
    send(1, 12'h3C7, 3, 0, 1, dummy);
    wait_drain(0);
    wait_drain(1);

    // Back-pressure with ignored in_valid pulses while DONE
    send(0, 12'h0C3, 2, 5, 1, dummy);
    begin
      int t = 0;
      while (!mon_valid[0] && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk(0, "bp_valid_wait", {31'b0, mon_valid[0]}, 1);
    end
    for (int k = 0; k < 3; k++) begin
      drv_valid[0] = (k != 1);
      drv_a[0]     = 12'($urandom);
      drv_enc[0]   = 4'($urandom);
      @(negedge clk);
    end
    drv_valid[0] = 1'b0;
    wait_drain(0);

    // Reset in the middle of a shift
    send(0, 12'h0A5, 6, 0, 0, dummy);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk(0, "async_rst_in_ready", {31'b0, mon_in_ready[0]}, 1);
    chk(0, "async_rst_busy", {31'b0, mon_busy[0]}, 0);
    chk(0, "async_rst_valid", {31'b0, mon_valid[0]}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk(0, "post_rst_in_ready", {31'b0, mon_in_ready[0]}, 1);
    chk(0, "post_rst_busy", {31'b0, mon_busy[0]}, 0);
    chk(0, "post_rst_res", {20'b0, mon_res[0]}, 0);
    send(0, 12'h0B0, 3, 0, 1, dummy);
    wait_drain(0);

    // Randomized traffic across both instances
    for (int n = 0; n < 80; n++) begin
      int i;
      i = int'($urandom_range(0, 1));
      send(i, 12'($urandom), (i == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 15)),
           int'($urandom_range(0, 2)), 1, dummy);
    end
    wait_drain(0);
    wait_drain(1);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
